// File: rtl/pmem_pkg.sv
// Shared types and widths for the word-granular physical-memory responder.
package pmem_pkg;

  localparam int unsigned MEM_WORD_W = 32;
  localparam int unsigned MEM_MASK_W = 4;
  localparam int unsigned LAT_CNT_W  = 4;
  localparam int unsigned JIT_W      = 2;
  localparam int unsigned LFSR_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

  typedef struct packed {
    logic                  wen;
    logic [MEM_WORD_W-1:0] addr;
    logic [MEM_WORD_W-1:0] wdata;
    logic [MEM_MASK_W-1:0] wmask;
  } pmem_req_t;

endpackage

// File: rtl/pmem_responder_if.sv
// Request/response valid-ready channels between the data-memory access unit and the responder.
interface pmem_responder_if;
  import pmem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [MEM_WORD_W-1:0] req_addr;
  logic [MEM_WORD_W-1:0] req_wdata;
  logic [MEM_MASK_W-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [MEM_WORD_W-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/pmem_jitter_lfsr.sv
// Free-running 4-bit LFSR giving 0..3 extra wait cycles; built only with PMEM_RESP_JITTER_EN.
`ifdef PMEM_RESP_JITTER_EN
module pmem_jitter_lfsr
  import pmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [JIT_W-1:0] extra
);

  logic [LFSR_W-1:0] lfsr_q;

  // x^4 + x^3 + 1, advances every cycle out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= 4'b1001;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
  end

  assign extra = lfsr_q[JIT_W-1:0];

endmodule
`endif

// File: rtl/pmem_responder.sv
// Word-granular memory responder: single outstanding read/masked-write with fixed latency.
// Optional latency jitter enabled by defining PMEM_RESP_JITTER_EN.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int unsigned           DEPTH_WORDS = 4096,
  parameter logic [MEM_WORD_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  pmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
`ifdef PMEM_RESP_JITTER_EN
  localparam int unsigned CNT_W = LAT_CNT_W + 1;
`else
  localparam int unsigned CNT_W = LAT_CNT_W;
`endif

  pmem_req_t             req;
  pmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, lat_total;
  logic                  rsp_valid_q;
  logic [MEM_WORD_W-1:0] rdata_q;
  logic                  err_q;
  logic [MEM_WORD_W-1:0] mem [DEPTH_WORDS];
  logic [MEM_WORD_W-1:0] word_idx;
  logic [IDX_W-1:0]      idx;
  logic                  addr_err;
  logic                  accept;

  assign req = '{wen:   bus.req_wen,
                 addr:  bus.req_addr,
                 wdata: bus.req_wdata,
                 wmask: bus.req_wmask};

  // Out of range when below the base (wrapped subtraction) or past the last word
  assign word_idx = (req.addr - BASE_ADDR) >> 2;
  assign addr_err = (req.addr < BASE_ADDR) || (word_idx >= MEM_WORD_W'(DEPTH_WORDS));
  assign idx      = word_idx[IDX_W-1:0];

`ifdef PMEM_RESP_JITTER_EN
  logic [JIT_W-1:0] extra;

  pmem_jitter_lfsr u_jitter (
    .clk   (clk),
    .rst   (rst),
    .extra (extra)
  );

  assign lat_total = CNT_W'(LATENCY) + CNT_W'(extra);
`else
  assign lat_total = CNT_W'(LATENCY);
`endif

  assign bus.req_ready = rst && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state: counter holds the remaining WAIT cycles before RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (lat_total == CNT_W'(1)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = lat_total - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_d == RESP);
      if (accept) begin
        err_q   <= addr_err;
        rdata_q <= (req.wen || addr_err) ? '0 : mem[idx];
      end
    end
  end

  // Backing array is not reset; writes commit on the accept edge
  always_ff @(posedge clk) begin
    if (accept && req.wen && !addr_err) begin
      for (int unsigned b = 0; b < MEM_MASK_W; b++) begin
        if (req.wmask[b]) begin
          mem[idx][8*b +: 8] <= req.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: LATENCY=2 instance under random traffic, LATENCY=1 back-to-back.
module tb_pmem_responder;
  import pmem_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned LAT0  = 2;
`ifdef PMEM_RESP_JITTER_EN
  localparam int JIT = 3;
`else
  localparam int JIT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_responder_if bus0();
  pmem_responder_if bus1();

  pmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [int unsigned];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memory as a sparse word map, range decided with 64-bit arithmetic
  function automatic exp_t model(input bit wen, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m);
    exp_t            e;
    longint unsigned la, lo, hi;
    int unsigned     w;
    logic [31:0]     bm;
    la = longint'(a);
    lo = longint'(BASE);
    hi = lo + 4 * longint'(DEPTH);
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.acc   = 0;
    if (la < lo || la >= hi) begin
      e.err = 1'b1;
    end else begin
      w = int'((la - lo) / 4);
      if (wen) begin
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        if (!mdl.exists(w)) mdl[w] = 32'h0;
        mdl[w] = (mdl[w] & ~bm) | (d & bm);
      end else begin
        e.rdata = mdl.exists(w) ? mdl[w] : 32'h0;
      end
    end
    return e;
  endfunction

  // Response-ready policy plus monitor/scoreboard for dut0
  logic        was_stalled = 1'b0;
  logic        rst_prev = 1'b1;
  logic [31:0] held_rdata;
  logic        held_err;
  int          stall = 0;

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    case (rdy_mode)
      0: bus0.rsp_ready = 1'b1;
      1: bus0.rsp_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (bus0.rsp_valid) stall++;
        else stall = 0;
        bus0.rsp_ready = (stall > 5);
      end
    endcase

    if (!rst_prev) begin
      chk(bus0.rsp_valid == 1'b0, "reset_rsp_valid", bus0.rsp_valid, 0);
      chk(bus0.rsp_rdata == 32'h0, "reset_rsp_rdata", bus0.rsp_rdata, 0);
      chk(bus0.rsp_err == 1'b0, "reset_rsp_err", bus0.rsp_err, 0);
    end

    if (!rst) begin
      chk(bus0.req_ready == 1'b0, "req_ready_in_reset", bus0.req_ready, 0);
      q.delete();
      was_stalled = 1'b0;
    end else begin
      if (bus0.rsp_valid) begin
        chk(bus0.req_ready == 1'b0, "req_ready_while_busy", bus0.req_ready, 0);
        if (was_stalled) begin
          chk(bus0.rsp_rdata == held_rdata, "hold_rdata", bus0.rsp_rdata, held_rdata);
          chk(bus0.rsp_err == held_err, "hold_err", bus0.rsp_err, held_err);
        end else begin
          chk(q.size() != 0, "unexpected_rsp", q.size(), 1);
          if (q.size() != 0) begin
            lat = cyc - q[0].acc + 1;
            chk(lat >= int'(LAT0) && lat <= int'(LAT0) + JIT, "latency", lat, LAT0);
          end
        end
        if (bus0.rsp_ready && q.size() != 0) begin
          e = q.pop_front();
          chk(bus0.rsp_rdata === e.rdata, "rsp_rdata", bus0.rsp_rdata, e.rdata);
          chk(bus0.rsp_err === e.err, "rsp_err", bus0.rsp_err, e.err);
        end
        was_stalled = !bus0.rsp_ready;
        held_rdata  = bus0.rsp_rdata;
        held_err    = bus0.rsp_err;
      end else begin
        chk(!was_stalled, "rsp_valid_dropped", 0, 1);
        was_stalled = 1'b0;
      end
      if (bus0.req_valid && bus0.req_ready) begin
        e = model(bus0.req_wen, bus0.req_addr, bus0.req_wdata, bus0.req_wmask);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
    rst_prev = rst;
  end

  task automatic issue0(input bit wen, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
    int t = 0;
    bus0.req_valid = 1'b1;
    bus0.req_wen   = wen;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
    bus0.req_wmask = m;
    do begin
      @(negedge clk);
      t++;
    end while (!bus0.req_ready && t < 100);
    chk(bus0.req_ready == 1'b1, "accept_timeout", t, 100);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || bus0.rsp_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input int k, input logic [31:0] wd [4]);
    bus1.req_valid = 1'b1;
    bus1.req_wmask = 4'hF;
    if (k == 8) begin
      bus1.req_wen   = 1'b0;
      bus1.req_addr  = BASE - 32'd4;
      bus1.req_wdata = 32'h0;
    end else begin
      bus1.req_wen   = (k % 2 == 0);
      bus1.req_addr  = BASE + 32'h100 + 32'(4 * (k / 2));
      bus1.req_wdata = wd[k / 2];
    end
  endtask

  // LATENCY=1 instance: back-to-back requests with rsp_ready held high
  task automatic run_lat1();
    logic [31:0] wd [4];
    logic [31:0] exp_rd;
    int          prev_acc = -1;
    int          acc;
    int          t;
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    set1(0, wd);
    for (int k = 0; k < 9; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus1.req_ready && t < 50);
      chk(bus1.req_ready == 1'b1, "l1_accept_timeout", t, 50);
      acc = cyc + 1;
      if (prev_acc >= 0) begin
        chk(acc - prev_acc >= 2 && acc - prev_acc <= 2 + JIT, "l1_spacing", acc - prev_acc, 2);
      end
      prev_acc = acc;
      @(posedge clk);
      #1;
      if (k < 8) set1(k + 1, wd);
      else bus1.req_valid = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus1.rsp_valid && t < 20);
      chk(bus1.rsp_valid && t >= 1 && t <= 1 + JIT, "l1_latency", t, 1);
      exp_rd = (k % 2 == 1 && k != 8) ? wd[k / 2] : 32'h0;
      chk(bus1.rsp_rdata === exp_rd, "l1_rdata", bus1.rsp_rdata, exp_rd);
      chk(bus1.rsp_err === (k == 8), "l1_err", bus1.rsp_err, (k == 8));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned pool [16];
    int unsigned r;
    logic [31:0] a;
    rst = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = 32'h0;
    bus0.req_wdata = 32'h0; bus0.req_wmask = 4'h0;
    bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_addr = 32'h0;
    bus1.req_wdata = 32'h0; bus1.req_wmask = 4'h0; bus1.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk(bus0.req_ready == 1'b1, "ready_after_reset", bus0.req_ready, 1);
    chk(bus1.req_ready == 1'b1, "l1_ready_after_reset", bus1.req_ready, 1);
    @(posedge clk);
    #1;

    // Full write then read back; partial merge; no-op mask
    issue0(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue0(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    issue0(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF);
    issue0(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0110);
    issue0(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    issue0(1'b1, BASE + 32'h20, 32'h5555_5555, 4'h0);
    issue0(1'b0, BASE + 32'h22, 32'h0, 4'h0);

    // Range boundaries; an out-of-range write must not alias onto word 0
    issue0(1'b1, BASE, 32'h0BAD_F00D, 4'hF);
    issue0(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    issue0(1'b0, BASE + 32'h4000, 32'h0, 4'h0);
    issue0(1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
    issue0(1'b0, BASE, 32'h0, 4'h0);
    issue0(1'b1, BASE + 32'h3FFC, 32'hCAFE_0001, 4'hF);
    issue0(1'b0, BASE + 32'h3FFC, 32'h0, 4'h0);
    wait_idle();

    // Response back-pressure with a competing request that must be ignored
    rdy_mode = 2;
    issue0(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    bus0.req_valid = 1'b1; bus0.req_wen = 1'b1; bus0.req_addr = BASE + 32'h10;
    bus0.req_wdata = 32'h0; bus0.req_wmask = 4'hF;
    repeat (4) @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    wait_idle();
    rdy_mode = 0;
    issue0(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    wait_idle();

    // Reset while a read is waiting; next read behaves normally
    issue0(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    issue0(1'b0, BASE + 32'h20, 32'h0, 4'h0);
    wait_idle();

    // Randomized traffic over a preloaded pool plus out-of-range addresses
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) pool[i] = $urandom_range(0, DEPTH - 1);
    pool[0] = 0;
    pool[1] = DEPTH - 1;
    for (int i = 0; i < 16; i++) issue0(1'b1, BASE + 32'(4 * pool[i]), $urandom, 4'hF);
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      a = BASE + 32'(4 * pool[$urandom_range(0, 15)]) + 32'($urandom_range(0, 3));
      if (r < 40) begin
        issue0(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      end else if (r < 85) begin
        issue0(1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        case ($urandom_range(0, 4))
          0: a = BASE - 32'd4;
          1: a = BASE + 32'(4 * DEPTH);
          2: a = 32'h0;
          3: a = 32'hFFFF_FFFC;
          default: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1 << 20));
        endcase
        issue0(1'($urandom_range(0, 1)), a | 32'($urandom_range(0, 3)), $urandom, 4'hF);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    rdy_mode = 0;

    run_lat1();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Word-granular physical-memory responder: the memory-side endpoint that serves the aligned 32-bit read and masked-write transactions produced by the core's data-memory access unit. It accepts one request at a time over a valid/ready request channel, holds a backing word array, and returns read data or a write acknowledgement over a valid/ready response channel after a fixed, parameterised latency. It replaces the zero-latency simulator-backed memory when the core runs against an RTL memory model.

## Interface
- DEPTH_WORDS, 4096: backing array size in 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored (requester aligns).
- req_wdata  in  32  write data, little-endian, byte i = bits [8i+7:8i].
- req_wmask  in  4  write byte enables; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).

## Operation
- States: IDLE, WAIT, RESP. Single outstanding transaction.
- IDLE: req_ready = 1. On req_valid && req_ready (accept edge): latch wen, error flag; load counter; go to WAIT, or straight to RESP when LATENCY = 1.
- Index = (req_addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction; error if req_addr < BASE_ADDR or index >= DEPTH_WORDS.
- Write, no error: on accept edge, byte i of array[index] takes req_wdata byte i where req_wmask[i] = 1; other bytes keep value. wmask = 0 is a legal no-op write that still responds.
- Read, no error: array[index] sampled on accept edge into rdata register; later writes cannot alter it (none can occur while busy).
- Error: array untouched, rsp_rdata = 0, rsp_err = 1.
- WAIT: counter decrements each cycle; enter RESP so that rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP: rsp_valid = 1, rsp_rdata/rsp_err stable until rsp_valid && rsp_ready; then IDLE.
- req_ready = 0 in WAIT and RESP; request inputs ignored there.

## Timing
- Reset (rst = 0 at an edge): state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0. req_ready = 0 while rst = 0, 1 from the first cycle with rst = 1.
- Array contents are not reset; reset mid-transaction abandons it (a write already committed on its accept edge stays committed; no response issued).
- Accept at edge T -> rsp_valid high from cycle T+LATENCY. Response handshake at edge R -> req_ready high in cycle R+1; earliest next accept edge R+1. Throughput: one transaction per LATENCY+1 cycles with rsp_ready held high.
- rsp_ready high before rsp_valid has no effect.
- rsp_ready low: RESP held indefinitely, outputs stable.

## Configuration
- PMEM_RESP_JITTER_EN defined: a 4-bit LFSR (seed 4'b1001 at reset, advances every cycle) adds 0..3 extra WAIT cycles per transaction, value = LFSR[1:0] sampled on accept edge; latency = LATENCY + extra.
- Undefined: latency exactly LATENCY, no LFSR logic.

## Structure
- Package pmem_pkg: state enum (IDLE/WAIT/RESP), MEM_WORD_W = 32, MEM_MASK_W = 4, latency counter width 4.
- One sub-module: pmem_jitter_lfsr (compiled only under PMEM_RESP_JITTER_EN), outputs the 2-bit extra delay.
- Array, address check, FSM in pmem_responder.

## Test plan
- Write 0xDEADBEEF, mask 4'b1111 to 0x8000_0010, then read 0x8000_0010 -> rsp_rdata 0xDEADBEEF, rsp_err 0, each rsp_valid exactly 2 cycles after accept.
- Preload 0x1122_3344 at 0x8000_0020; write 0xAABB_CCDD mask 4'b0110 -> read returns 0x11BB_CC44.
- Read 0x7FFF_FFFC and 0x8000_4000 (DEPTH_WORDS 4096) -> rsp_err 1, rsp_rdata 0; write to 0x8000_4000 leaves array unchanged.
- Hold rsp_ready 0 for 5 cycles after rsp_valid -> rsp_valid/rdata stable, req_ready 0; new req_valid ignored until response handshake.
- Assert rst = 0 in WAIT of a read -> next cycle rsp_valid 0, state IDLE; following read returns correct data with normal latency.
- LATENCY = 1, back-to-back requests with rsp_ready = 1 -> accepts every 2 cycles, rsp_valid one cycle after each accept.
